sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 Parameter: DATA_WIDTH, default 16, width of the data path in bits.
REQ-002 Parameter: FIFO_DEPTH, default 8, number of entries; range 2..1024; need not be a power of two.
REQ-003 Parameter: AFULL_THRESH, default FIFO_DEPTH-1, count at or above which almostfull asserts; legal range 1..FIFO_DEPTH-1.
REQ-004 Parameter: AEMPTY_THRESH, default 1, count at or below which almostempty asserts; legal range 1..FIFO_DEPTH-1.
REQ-005 Parameter: FWFT, default 0; 0 selects standard read mode, 1 selects first-word-fall-through mode.
REQ-006 Port: clk  input  1  single clock; all state changes on its rising edge.
REQ-007 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-008 Port: flush  input  1  synchronous clear of FIFO contents.
REQ-009 Port: wr_en  input  1  write request.
REQ-010 Port: data_in  input  DATA_WIDTH  write data.
REQ-011 Port: rd_en  input  1  read request.
REQ-012 Port: data_out  output  DATA_WIDTH  read data.
REQ-013 Port: count  output  CW = $clog2(FIFO_DEPTH+1)  number of stored entries.
REQ-014 Ports: full, empty, almostfull, almostempty  output  1 each  occupancy flags, combinational from count.
REQ-015 Ports: wr_ack, overflow, underflow  output  1 each  registered single-cycle status pulses.

Function
REQ-016 Write is accepted when wr_en=1, full=0 and flush=0; data_in goes to mem[wr_ptr], and wr_ptr advances.
REQ-017 Read is accepted when rd_en=1, empty=0 and flush=0; rd_ptr advances.
REQ-018 Pointers wrap from FIFO_DEPTH-1 to 0, including for non-power-of-two depths.
REQ-019 Count update: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-020 Full with wr_en=1 and rd_en=1: the read is accepted, the write is rejected, and count decrements.
REQ-021 Empty with wr_en=1 and rd_en=1: the write is accepted, the read is rejected, and count becomes 1.
REQ-022 Flags: full = (count==FIFO_DEPTH); empty = (count==0); almostfull = (count>=AFULL_THRESH && !full); almostempty = (count<=AEMPTY_THRESH && !empty).
REQ-023 wr_ack is high for exactly the one cycle following an accepted write.
REQ-024 overflow is high for the one cycle following a cycle with wr_en=1, full=1 and flush=0.
REQ-025 underflow is high for the one cycle following a cycle with rd_en=1, empty=1 and flush=0.
REQ-026 FWFT=0: data_out is registered and updated with mem[rd_ptr] on the edge of an accepted read (latency 1); otherwise it holds.
REQ-027 FWFT=1: data_out continuously equals mem[rd_ptr] when empty=0; an accepted read pops that word; data_out is don't-care while empty=1.
REQ-028 FWFT=1: a word written into an empty FIFO appears on data_out in the cycle after the write edge.
REQ-029 Flush has priority over wr_en and rd_en.
REQ-030 On flush, wr_ptr, rd_ptr and count clear to 0 at the next edge.
REQ-031 A flush cycle raises none of wr_ack, overflow or underflow, and data_out (FWFT=0) holds its value.
REQ-032 The memory array is not cleared by reset or flush.

Reset
REQ-033 While rst_n=0, asynchronously: pointers=0, count=0, data_out=0, wr_ack=0, overflow=0, underflow=0; hence empty=1 and full, almostfull, almostempty all 0.
REQ-034 Reset asserted mid-operation discards all contents; the first edge after deassertion behaves as from an empty FIFO.

Verification (DEPTH=8, DATA_WIDTH=16, defaults unless stated)
REQ-035 Write 8 words 0x0001..0x0008, then one extra write:
  - count goes 1..8; almostempty at count 1; almostfull at count 7; full at count 8.
  - wr_ack pulses 8 times; the 9th write gives overflow=1 for one cycle and count stays 8.
REQ-036 FWFT=0, read 8 words after the fill:
  - data_out = 0x0001..0x0008, each one cycle after its rd_en.
  - A 9th read gives underflow=1 for one cycle and empty=1.
REQ-037 Simultaneous writes and reads:
  - Full + simultaneous wr/rd: count 8->7, overflow=1, and the rejected data does not appear later.
  - Empty + simultaneous wr/rd: count 0->1, underflow=1.
REQ-038 FWFT=1, write 0xABCD into an empty FIFO: data_out=0xABCD the next cycle with no rd_en; rd_en pops it and empty=1.
REQ-039 Count 5, assert flush together with wr_en and rd_en: next cycle count=0, empty=1, no status pulses; a subsequent write/read returns the new word.
REQ-040 DEPTH=6, AFULL_THRESH=4, AEMPTY_THRESH=2, 20 writes and reads interleaved:
  - Pointers wrap correctly and data order is preserved.
  - almostfull at count>=4 and <6; almostempty at count 1..2.
  - rst_n pulsed low mid-stream clears all outputs immediately.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Synchronous single-clock FIFO with programmable depth (any size 2..1024),
// almost-full/almost-empty thresholds, registered status pulses, and a
// selectable standard or first-word-fall-through read port.
module sync_fifo_param #(
  parameter int DATA_WIDTH    = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
  parameter int AEMPTY_THRESH = 1,
  parameter int FWFT          = 0,
  localparam int CW = $clog2(FIFO_DEPTH + 1),
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow
);

  // Storage is deliberately left out of reset/flush; only control is cleared.
  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]         r_wr_ptr;
  logic [PW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic w_wr_acc;
  logic w_rd_acc;

  // Pointer advance with explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] f_next_ptr(input logic [PW-1:0] ptr);
    if (ptr == PW'(FIFO_DEPTH - 1)) return '0;
    return ptr + PW'(1);
  endfunction

  assign count       = r_count;
  assign full        = (r_count == CW'(FIFO_DEPTH));
  assign empty       = (r_count == '0);
  assign almostfull  = (r_count >= CW'(AFULL_THRESH)) && !full;
  assign almostempty = (r_count <= CW'(AEMPTY_THRESH)) && !empty;

  // Flush blocks both ports; a full FIFO still reads and an empty one still writes.
  assign w_wr_acc = wr_en && !full  && !flush;
  assign w_rd_acc = rd_en && !empty && !flush;

  // Write the storage array on an accepted write.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= data_in;
  end

  // Pointer and occupancy bookkeeping; flush clears them synchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= f_next_ptr(r_wr_ptr);
      if (w_rd_acc) r_rd_ptr <= f_next_ptr(r_rd_ptr);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // One-cycle status pulses describing what happened at the previous edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ack    <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wr_ack    <= w_wr_acc;
      overflow  <= wr_en && full  && !flush;
      underflow <= rd_en && empty && !flush;
    end
  end

  generate
    if (FWFT == 0) begin : g_std
      logic [DATA_WIDTH-1:0] r_data_out;
      // Standard mode: capture the head word on the edge that pops it.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_data_out <= '0;
        else if (w_rd_acc) r_data_out <= r_mem[r_rd_ptr];
      end
      assign data_out = r_data_out;
    end else begin : g_fwft
      // Head word is always visible; forced to zero while empty so reset reads 0.
      assign data_out = empty ? '0 : r_mem[r_rd_ptr];
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: three instances (depth 8 standard, depth 8 FWFT,
// depth 6 with custom thresholds) share one stimulus stream and are checked
// every cycle against a queue-style model plus hand-computed expectations.
module tb_sync_fifo_param;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] data_in = '0;

  logic [2:0][15:0] dout_v;
  logic [3:0]       cnt0, cnt1;
  logic [2:0]       cnt6;
  logic [2:0]       full_v, empty_v, af_v, ae_v, ack_v, ovf_v, unf_v;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(dout_v[0]), .count(cnt0), .full(full_v[0]),
    .empty(empty_v[0]), .almostfull(af_v[0]), .almostempty(ae_v[0]),
    .wr_ack(ack_v[0]), .overflow(ovf_v[0]), .underflow(unf_v[0]));

  sync_fifo_param #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .FWFT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(dout_v[1]), .count(cnt1), .full(full_v[1]),
    .empty(empty_v[1]), .almostfull(af_v[1]), .almostempty(ae_v[1]),
    .wr_ack(ack_v[1]), .overflow(ovf_v[1]), .underflow(unf_v[1]));

  sync_fifo_param #(.DATA_WIDTH(16), .FIFO_DEPTH(6), .AFULL_THRESH(4),
                    .AEMPTY_THRESH(2), .FWFT(0)) u2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(dout_v[2]), .count(cnt6), .full(full_v[2]),
    .empty(empty_v[2]), .almostfull(af_v[2]), .almostempty(ae_v[2]),
    .wr_ack(ack_v[2]), .overflow(ovf_v[2]), .underflow(unf_v[2]));

  function automatic int dep(int i);
    return (i == 2) ? 6 : 8;
  endfunction
  function automatic int afth(int i);
    return (i == 2) ? 4 : 7;
  endfunction
  function automatic int aeth(int i);
    return (i == 2) ? 2 : 1;
  endfunction
  function automatic int act_cnt(int i);
    case (i)
      0:       return int'(cnt0);
      1:       return int'(cnt1);
      default: return int'(cnt6);
    endcase
  endfunction

  task automatic chk(input string nm, input int i, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s u%0d got 0x%0h expected 0x%0h at %0t", nm, i, act, exp, $time);
    end
  endtask

  // Model: contents kept as an ordered list with the oldest word at index 0.
  logic [15:0] m_data [3][16];
  int          m_cnt  [3];
  logic [15:0] m_dout [3];
  bit          m_ack  [3];
  bit          m_ovf  [3];
  bit          m_unf  [3];

  always @(posedge clk or negedge rst_n) begin
    bit wr_ok, rd_ok;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_cnt[i] = 0; m_dout[i] = '0;
        m_ack[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      end else if (flush) begin
        m_cnt[i] = 0;
        m_ack[i] = 0; m_ovf[i] = 0; m_unf[i] = 0;
      end else begin
        wr_ok    = wr_en && (m_cnt[i] < dep(i));
        rd_ok    = rd_en && (m_cnt[i] > 0);
        m_ack[i] = wr_ok;
        m_ovf[i] = wr_en && (m_cnt[i] == dep(i));
        m_unf[i] = rd_en && (m_cnt[i] == 0);
        if (rd_ok) begin
          if (i != 1) m_dout[i] = m_data[i][0];
          for (int j = 0; j < 15; j++) m_data[i][j] = m_data[i][j+1];
          m_cnt[i] = m_cnt[i] - 1;
        end
        if (wr_ok) begin
          m_data[i][m_cnt[i]] = data_in;
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("count",       i, act_cnt(i), m_cnt[i]);
      chk("full",        i, int'(full_v[i]),  int'(m_cnt[i] == dep(i)));
      chk("empty",       i, int'(empty_v[i]), int'(m_cnt[i] == 0));
      chk("almostfull",  i, int'(af_v[i]),  int'(m_cnt[i] >= afth(i) && m_cnt[i] != dep(i)));
      chk("almostempty", i, int'(ae_v[i]),  int'(m_cnt[i] <= aeth(i) && m_cnt[i] != 0));
      chk("wr_ack",      i, int'(ack_v[i]), int'(m_ack[i]));
      chk("overflow",    i, int'(ovf_v[i]), int'(m_ovf[i]));
      chk("underflow",   i, int'(unf_v[i]), int'(m_unf[i]));
      if (i != 1)          chk("data_out", i, int'(dout_v[i]), int'(m_dout[i]));
      else if (m_cnt[i] > 0) chk("data_out", i, int'(dout_v[i]), int'(m_data[i][0]));
    end
  end

  task automatic cycle(input bit w, input bit r, input bit f, input logic [15:0] d);
    wr_en = w; rd_en = r; flush = f; data_in = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int nw;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 0, int'(cnt0), 0);
    chk("rst_empty", 0, int'(empty_v[0]), 1);
    chk("rst_dout",  0, int'(dout_v[0]), 0);
    rst_n = 1'b1;
    cycle(0, 0, 0, 16'h0);

    // Fill with 1..8 and one extra write.
    for (int k = 1; k <= 8; k++) begin
      cycle(1, 0, 0, 16'(k));
      chk("fill_count", 0, int'(cnt0), k);
      chk("fill_ack",   0, int'(ack_v[0]), 1);
      chk("fill_ae",    0, int'(ae_v[0]), int'(k == 1));
      chk("fill_af",    0, int'(af_v[0]), int'(k == 7));
      chk("fill_full",  0, int'(full_v[0]), int'(k == 8));
      chk("fill_full",  2, int'(full_v[2]), int'(k >= 6));
      chk("fill_af",    2, int'(af_v[2]), int'(k == 4 || k == 5));
      chk("fill_ae",    2, int'(ae_v[2]), int'(k <= 2));
    end
    chk("fwft_head", 1, int'(dout_v[1]), 16'h0001);
    cycle(1, 0, 0, 16'h0009);
    chk("ovf_pulse",  0, int'(ovf_v[0]), 1);
    chk("ovf_count",  0, int'(cnt0), 8);
    chk("ovf_noack",  0, int'(ack_v[0]), 0);
    cycle(0, 0, 0, 16'h0);
    chk("ovf_clear",  0, int'(ovf_v[0]), 0);

    // Drain 1..8, then one read too many.
    for (int k = 1; k <= 8; k++) begin
      cycle(0, 1, 0, 16'h0);
      chk("read_data", 0, int'(dout_v[0]), k);
      if (k < 8) chk("fwft_next", 1, int'(dout_v[1]), k + 1);
    end
    cycle(0, 1, 0, 16'h0);
    chk("unf_pulse", 0, int'(unf_v[0]), 1);
    chk("unf_empty", 0, int'(empty_v[0]), 1);
    chk("unf_hold",  0, int'(dout_v[0]), 16'h0008);

    // Full with simultaneous write and read: rejected word must never emerge.
    for (int k = 0; k < 8; k++) cycle(1, 0, 0, 16'(16'h10 + k));
    cycle(1, 1, 0, 16'hDEAD);
    chk("fullrw_count", 0, int'(cnt0), 7);
    chk("fullrw_ovf",   0, int'(ovf_v[0]), 1);
    chk("fullrw_data",  0, int'(dout_v[0]), 16'h0010);
    for (int k = 0; k < 7; k++) begin
      cycle(0, 1, 0, 16'h0);
      chk("fullrw_drain", 0, int'(dout_v[0]), 16'h11 + k);
    end

    // Empty with simultaneous write and read.
    cycle(1, 1, 0, 16'h55AA);
    chk("emptyrw_count", 0, int'(cnt0), 1);
    chk("emptyrw_unf",   0, int'(unf_v[0]), 1);
    chk("emptyrw_ack",   0, int'(ack_v[0]), 1);
    cycle(0, 1, 0, 16'h0);
    chk("emptyrw_data",  0, int'(dout_v[0]), 16'h55AA);

    // FWFT fall-through of a single word.
    cycle(1, 0, 0, 16'hABCD);
    chk("fwft_show",  1, int'(dout_v[1]), 16'hABCD);
    cycle(0, 0, 0, 16'h0);
    chk("fwft_stay",  1, int'(dout_v[1]), 16'hABCD);
    cycle(0, 1, 0, 16'h0);
    chk("fwft_empty", 1, int'(empty_v[1]), 1);
    chk("std_abcd",   0, int'(dout_v[0]), 16'hABCD);

    // Flush beats a simultaneous write and read.
    for (int k = 0; k < 5; k++) cycle(1, 0, 0, 16'(16'h31 + k));
    chk("preflush_count", 0, int'(cnt0), 5);
    cycle(1, 1, 1, 16'h0099);
    chk("flush_count", 0, int'(cnt0), 0);
    chk("flush_empty", 0, int'(empty_v[0]), 1);
    chk("flush_ack",   0, int'(ack_v[0]), 0);
    chk("flush_ovf",   0, int'(ovf_v[0]), 0);
    chk("flush_unf",   0, int'(unf_v[0]), 0);
    chk("flush_hold",  0, int'(dout_v[0]), 16'hABCD);
    cycle(1, 0, 0, 16'h4242);
    chk("postflush_fwft", 1, int'(dout_v[1]), 16'h4242);
    cycle(0, 1, 0, 16'h0);
    chk("postflush_data", 0, int'(dout_v[0]), 16'h4242);

    // Interleaved traffic with a mid-stream reset.
    nw = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == 9) begin
        rst_n = 1'b0;
        #2;
        chk("midrst_count", 2, int'(cnt6), 0);
        chk("midrst_count", 0, int'(cnt0), 0);
        chk("midrst_empty", 2, int'(empty_v[2]), 1);
        chk("midrst_dout",  2, int'(dout_v[2]), 0);
        chk("midrst_ack",   2, int'(ack_v[2] | ovf_v[2] | unf_v[2]), 0);
        chk("midrst_flags", 2, int'(full_v[2] | af_v[2] | ae_v[2]), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
      end
      if (nw < 20 && (k % 4) != 3) begin
        cycle(1, (k % 3) != 0, 0, 16'(16'h100 + nw));
        nw++;
      end else begin
        cycle(0, (k % 3) != 0 || nw >= 20, 0, 16'h0);
      end
    end

    cycle(0, 0, 0, 16'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
